// File: rtl/rf_wb_arbiter_pkg.sv
// Shared writeback definitions: writeback-source codes, arbiter state
// encodings, register-index width and the x0 constant.
package rf_wb_arbiter_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    // Writeback source mux selections used by the pipeline WB stage.
    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC4 = 2'd2,
        WB_SRC_IMM = 2'd3
    } wb_src_t;

    // Register-file write-port arbiter states.
    typedef enum logic [1:0] {
        WBA_IDLE  = 2'd0,
        WBA_PEND  = 2'd1,
        WBA_FORCE = 2'd2
    } wba_state_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Long-unit result FIFO: DEPTH entries of {valid, wr, wd}. Entries can be
// invalidated by destination address (WAW kill) while keeping their slot,
// and two compare ports report whether a register has a valid entry.
module wb_arb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [REG_W-1:0]         push_wr,
    input  logic [31:0]              push_wd,
    input  logic                     pop,
    input  logic                     kill,
    input  logic [REG_W-1:0]         kill_wr,
    input  logic [REG_W-1:0]         rs1_addr,
    input  logic [REG_W-1:0]         rs2_addr,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [REG_W-1:0]         head_wr,
    output logic [31:0]              head_wd,
    output logic                     rs1_hit,
    output logic                     rs2_hit
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [REG_W-1:0] wr_q [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic [PW-1:0]    widx;
    logic [PW-1:0]    ridx;

    assign widx = wptr[PW-1:0];
    assign ridx = rptr[PW-1:0];

    // Pointer, entry and kill updates; a push always lands in a free slot,
    // so it never collides with the kill or pop of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wr_q[i] <= '0;
                wd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && valid[i] && (wr_q[i] == kill_wr)) begin
                    valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid[ridx] <= 1'b0;
                rptr        <= rptr + 1'b1;
            end
            if (push) begin
                valid[widx] <= 1'b1;
                wr_q[widx]  <= push_wr;
                wd_q[widx]  <= push_wd;
                wptr        <= wptr + 1'b1;
            end
        end
    end

    assign count      = wptr - rptr;
    assign full       = (wptr[PW] != rptr[PW]) && (widx == ridx);
    assign head_valid = valid[ridx];
    assign head_wr    = wr_q[ridx];
    assign head_wd    = wd_q[ridx];

    // Hazard lookup: any valid entry targeting a non-x0 register.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (wr_q[i] == rs1_addr) && (rs1_addr != REG_X0)) rs1_hit = 1'b1;
            if (valid[i] && (wr_q[i] == rs2_addr) && (rs2_addr != REG_X0)) rs2_hit = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-unit
// results are buffered and drained into free slots, and a starvation counter
// forces a one-cycle pipeline stall. Optional statistics counters are built
// when WB_ARB_STAT_EN is defined.
//
// Long-unit handshake: lu_ready is asserted whenever the FIFO is not full
// (independent of lu_valid and of any same-cycle dequeue); a result transfers
// on a rising clock edge where lu_valid && lu_ready, and the long unit must
// hold lu_wr/lu_wd stable while lu_valid is high and lu_ready is low.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             pipe_we,
    input  logic [REG_W-1:0] pipe_wr,
    input  logic [31:0]      pipe_wd,
    input  logic             lu_valid,
    input  logic [REG_W-1:0] lu_wr,
    input  logic [31:0]      lu_wd,
    output logic             lu_ready,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_wr,
    output logic [31:0]      rf_wd,
    output logic             pipe_stall,
    input  logic [REG_W-1:0] rs1_addr,
    input  logic [REG_W-1:0] rs2_addr,
    output logic             rs1_pend,
    output logic             rs2_pend,
`ifdef WB_ARB_STAT_EN
    output logic [15:0]      stat_force,
    output logic [15:0]      stat_conflict,
`endif
    output wba_state_t       dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
    localparam logic [PW:0]   ONE      = (PW + 1)'(1);

    wba_state_t       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             full, push, pop, kill;
    logic [PW:0]      count;
    logic             head_valid;
    logic [REG_W-1:0] head_wr;
    logic [31:0]      head_wd;
    logic             pipe_ok, slot_free, rf_we_i, stall_i;

    assign pipe_ok   = pipe_we && (pipe_wr != REG_X0);
    assign slot_free = !pipe_ok;
    assign lu_ready  = !full && !cpu_rst;
    assign push      = lu_valid && lu_ready && (lu_wr != REG_X0);

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (cpu_clk),
        .rst        (cpu_rst),
        .push       (push),
        .push_wr    (lu_wr),
        .push_wd    (lu_wd),
        .pop        (pop),
        .kill       (kill),
        .kill_wr    (pipe_wr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .full       (full),
        .count      (count),
        .head_valid (head_valid),
        .head_wr    (head_wr),
        .head_wd    (head_wd),
        .rs1_hit    (rs1_pend),
        .rs2_hit    (rs2_pend)
    );

    // State and starvation-counter registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= WBA_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Slot arbitration: next state, counter, FIFO pop/kill and write port.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        kill    = 1'b0;
        stall_i = 1'b0;
        rf_we_i = 1'b0;
        rf_wr   = pipe_wr;
        rf_wd   = pipe_wd;
        case (state)
            WBA_IDLE: begin
                rf_we_i = pipe_ok;
                kill    = pipe_ok;
                if (push) state_n = WBA_PEND;
            end
            WBA_PEND: begin
                if (slot_free) begin
                    pop     = 1'b1;
                    rf_we_i = head_valid;
                    rf_wr   = head_wr;
                    rf_wd   = head_wd;
                    cnt_n   = '0;
                    if ((count == ONE) && !push) state_n = WBA_IDLE;
                end else begin
                    rf_we_i = 1'b1;
                    kill    = 1'b1;
                    cnt_n   = cnt + 1'b1;
                    if (cnt_n == WAIT_LIM) state_n = WBA_FORCE;
                end
            end
            WBA_FORCE: begin
                stall_i = 1'b1;
                pop     = 1'b1;
                rf_we_i = head_valid;
                rf_wr   = head_wr;
                rf_wd   = head_wd;
                cnt_n   = '0;
                state_n = ((count != ONE) || push) ? WBA_PEND : WBA_IDLE;
            end
            default: begin
                state_n = WBA_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign rf_we      = rf_we_i && !cpu_rst;
    assign pipe_stall = stall_i && !cpu_rst;
    assign dbg_state  = state;

`ifdef WB_ARB_STAT_EN
    logic conflict;
    assign conflict = (state == WBA_PEND) && !slot_free;

    // Saturating counts of forced slots and denied head cycles.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stat_force    <= '0;
            stat_conflict <= '0;
        end else begin
            if ((state == WBA_FORCE) && (stat_force != 16'hFFFF)) stat_force <= stat_force + 1'b1;
            if (conflict && (stat_conflict != 16'hFFFF)) stat_conflict <= stat_conflict + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (DEPTH=2, MAX_WAIT=4). Inputs change
// 1ns after the rising edge; outputs are checked at the falling edge. Every
// register-file write is logged and compared with the expected write queue.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        pipe_we;
    logic [4:0]  pipe_wr;
    logic [31:0] pipe_wd;
    logic        lu_valid;
    logic [4:0]  lu_wr;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic        pipe_stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pend;
    logic        rs2_pend;
`ifdef WB_ARB_STAT_EN
    logic [15:0] stat_force;
    logic [15:0] stat_conflict;
`endif
    wba_state_t  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [36:0] exp_q[$];
    logic [36:0] got_q[$];

    rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .pipe_we       (pipe_we),
        .pipe_wr       (pipe_wr),
        .pipe_wd       (pipe_wd),
        .lu_valid      (lu_valid),
        .lu_wr         (lu_wr),
        .lu_wd         (lu_wd),
        .lu_ready      (lu_ready),
        .rf_we         (rf_we),
        .rf_wr         (rf_wr),
        .rf_wd         (rf_wd),
        .pipe_stall    (pipe_stall),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_pend      (rs1_pend),
        .rs2_pend      (rs2_pend),
`ifdef WB_ARB_STAT_EN
        .stat_force    (stat_force),
        .stat_conflict (stat_conflict),
`endif
        .dbg_state     (dbg_state)
    );

    // Clock: 10ns period.
    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Write monitor: log every register-file write at the falling edge.
    always @(negedge cpu_clk) begin
        if (!cpu_rst && rf_we) got_q.push_back({rf_wr, rf_wd});
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive_pipe(input logic we, input logic [4:0] wr, input logic [31:0] wd);
        pipe_we = we;
        pipe_wr = wr;
        pipe_wd = wd;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] wr, input logic [31:0] wd);
        lu_valid = v;
        lu_wr    = wr;
        lu_wd    = wd;
    endtask

    task automatic adv();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] wr, input logic [31:0] wd);
        exp_q.push_back({wr, wd});
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] wr, input logic [31:0] wd);
        chk({tag, "_we"}, 40'(rf_we), 40'(we));
        if (we) begin
            chk({tag, "_wr"}, 40'(rf_wr), 40'(wr));
            chk({tag, "_wd"}, 40'(rf_wd), 40'(wd));
        end
    endtask

    initial begin
        cpu_rst  = 1'b1;
        drive_pipe(1'b1, 5'd5, 32'h11);
        drive_lu(1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;

        // Reset held: outputs forced low even with pipe_we asserted.
        #1;
        chk("rst_lu_ready", 40'(lu_ready), 40'(0));
        chk("rst_rf_we", 40'(rf_we), 40'(0));
        chk("rst_stall", 40'(pipe_stall), 40'(0));
        chk("rst_state", 40'(dbg_state), 40'(WBA_IDLE));
        adv();
        adv();
        cpu_rst = 1'b0;

        // Pipeline write x5=0x11 goes straight through.
        @(negedge cpu_clk);
        chk_rf("pipe_x5", 1'b1, 5'd5, 32'h11);
        chk("pipe_lu_ready", 40'(lu_ready), 40'(1));
        expect_wr(5'd5, 32'h11);

        // Long result x7=0xAB, written one cycle after acceptance.
        adv();
        drive_pipe(1'b0, 5'd0, 32'h0);
        drive_lu(1'b1, 5'd7, 32'hAB);
        rs1_addr = 5'd7;
        @(negedge cpu_clk);
        chk("lu7_ready", 40'(lu_ready), 40'(1));
        chk("lu7_no_bypass", 40'(rf_we), 40'(0));
        chk("lu7_state0", 40'(dbg_state), 40'(WBA_IDLE));
        adv();
        drive_lu(1'b0, 5'd0, 32'h0);
        @(negedge cpu_clk);
        chk_rf("lu7_wr", 1'b1, 5'd7, 32'hAB);
        chk("lu7_state1", 40'(dbg_state), 40'(WBA_PEND));
        chk("lu7_pend", 40'(rs1_pend), 40'(1));
        expect_wr(5'd7, 32'hAB);
        adv();
        @(negedge cpu_clk);
        chk("lu7_state2", 40'(dbg_state), 40'(WBA_IDLE));
        chk("lu7_pend_clr", 40'(rs1_pend), 40'(0));

        // Starvation: x3 queued behind a busy pipeline writing x9.
        adv();
        drive_pipe(1'b1, 5'd9, 32'h99);
        drive_lu(1'b1, 5'd3, 32'h33);
        @(negedge cpu_clk);
        chk_rf("st_enq", 1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        for (int i = 0; i < 4; i++) begin
            adv();
            drive_lu(1'b0, 5'd0, 32'h0);
            @(negedge cpu_clk);
            chk_rf("st_deny", 1'b1, 5'd9, 32'h99);
            chk("st_deny_stall", 40'(pipe_stall), 40'(0));
            chk("st_deny_state", 40'(dbg_state), 40'(WBA_PEND));
            expect_wr(5'd9, 32'h99);
        end
        adv();
        @(negedge cpu_clk);
        chk("st_force_state", 40'(dbg_state), 40'(WBA_FORCE));
        chk("st_force_stall", 40'(pipe_stall), 40'(1));
        chk_rf("st_force", 1'b1, 5'd3, 32'h33);
        expect_wr(5'd3, 32'h33);
        adv();
        @(negedge cpu_clk);
        chk("st_after_state", 40'(dbg_state), 40'(WBA_IDLE));
        chk("st_after_stall", 40'(pipe_stall), 40'(0));
        chk_rf("st_after", 1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
`ifdef WB_ARB_STAT_EN
        chk("stat_force", 40'(stat_force), 40'(1));
        chk("stat_conflict", 40'(stat_conflict), 40'(4));
`endif

        // WAW kill: x4=0x1 queued, pipeline then writes x4=0x2.
        adv();
        drive_pipe(1'b0, 5'd0, 32'h0);
        drive_lu(1'b1, 5'd4, 32'h1);
        rs1_addr = 5'd4;
        @(negedge cpu_clk);
        chk("kill_pend0", 40'(rs1_pend), 40'(0));
        adv();
        drive_lu(1'b0, 5'd0, 32'h0);
        drive_pipe(1'b1, 5'd4, 32'h2);
        @(negedge cpu_clk);
        chk("kill_pend1", 40'(rs1_pend), 40'(1));
        chk_rf("kill_pipe", 1'b1, 5'd4, 32'h2);
        expect_wr(5'd4, 32'h2);
        adv();
        drive_pipe(1'b0, 5'd0, 32'h0);
        @(negedge cpu_clk);
        chk("kill_pend2", 40'(rs1_pend), 40'(0));
        chk("kill_pop_state", 40'(dbg_state), 40'(WBA_PEND));
        chk("kill_pop_we", 40'(rf_we), 40'(0));
        adv();
        @(negedge cpu_clk);
        chk("kill_state_idle", 40'(dbg_state), 40'(WBA_IDLE));

        // Fill: x10, x11 queued behind the pipeline; x12 held while full.
        adv();
        drive_pipe(1'b1, 5'd9, 32'h99);
        drive_lu(1'b1, 5'd10, 32'hA0);
        @(negedge cpu_clk);
        chk("fill_rdy0", 40'(lu_ready), 40'(1));
        chk_rf("fill_p0", 1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        adv();
        drive_lu(1'b1, 5'd11, 32'hB0);
        @(negedge cpu_clk);
        chk("fill_rdy1", 40'(lu_ready), 40'(1));
        chk_rf("fill_p1", 1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        adv();
        drive_lu(1'b1, 5'd12, 32'hC0);
        @(negedge cpu_clk);
        chk("fill_full", 40'(lu_ready), 40'(0));
        chk_rf("fill_p2", 1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        adv();
        drive_pipe(1'b0, 5'd0, 32'h0);
        @(negedge cpu_clk);
        chk("fill_full_deq", 40'(lu_ready), 40'(0));
        chk_rf("fill_d10", 1'b1, 5'd10, 32'hA0);
        expect_wr(5'd10, 32'hA0);
        adv();
        @(negedge cpu_clk);
        chk("fill_rdy_free", 40'(lu_ready), 40'(1));
        chk_rf("fill_d11", 1'b1, 5'd11, 32'hB0);
        expect_wr(5'd11, 32'hB0);
        adv();
        drive_pipe(1'b1, 5'd9, 32'h99);
        drive_lu(1'b1, 5'd13, 32'hD0);
        @(negedge cpu_clk);
        chk("fill_rdy13", 40'(lu_ready), 40'(1));
        chk_rf("fill_p3", 1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        adv();
        drive_lu(1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd12;
        rs2_addr = 5'd13;
        @(negedge cpu_clk);
        chk("fill_full2", 40'(lu_ready), 40'(0));
        chk("fill_pend12", 40'(rs1_pend), 40'(1));
        chk("fill_pend13", 40'(rs2_pend), 40'(1));
        chk_rf("fill_p4", 1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);

        // Asynchronous reset mid-cycle with two entries queued.
        adv();
        #2;
        cpu_rst = 1'b1;
        #1;
        chk("arst_rf_we", 40'(rf_we), 40'(0));
        chk("arst_lu_ready", 40'(lu_ready), 40'(0));
        chk("arst_stall", 40'(pipe_stall), 40'(0));
        chk("arst_state", 40'(dbg_state), 40'(WBA_IDLE));
        chk("arst_pend12", 40'(rs1_pend), 40'(0));
        chk("arst_pend13", 40'(rs2_pend), 40'(0));
        adv();
        cpu_rst = 1'b0;
        drive_pipe(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            chk("post_rst_we", 40'(rf_we), 40'(0));
            chk("post_rst_state", 40'(dbg_state), 40'(WBA_IDLE));
            chk("post_rst_rdy", 40'(lu_ready), 40'(1));
            adv();
        end

        // Scoreboard: every logged write must match the expected sequence.
        chk("log_size", 40'(got_q.size()), 40'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("log_%0d", i), 40'(got_q[i]), 40'(exp_q[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
